inv_full_adder_pbit: RTL and testbench



---
 rtl/inv_pbit_pkg.sv | 83 ++++++++
 rtl/pbit_cell.sv | 43 ++++
 rtl/inv_full_adder_pbit.sv | 68 ++++++
 tb/tb_inv_full_adder_pbit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/inv_pbit_pkg.sv
// Shared constants and helpers for the invertible p-bit full adder.
// Holds the coupling matrix, bit indices, LFSR polynomial and threshold LUT.
// No state; pure compile-time and combinational helpers.
package inv_pbit_pkg;

  localparam int NUM_BITS = 5;

  localparam int IDX_A    = 0;
  localparam int IDX_B    = 1;
  localparam int IDX_CIN  = 2;
  localparam int IDX_S    = 3;
  localparam int IDX_COUT = 4;

  // Threshold LUT resolution; random numbers are compared at this width
  localparam int THR_W = 8;

  // Galois right-shift form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] SEED_STEP = 16'h1F35;

  typedef logic signed [2:0] coef_t;   // coupling weight, -2..+2
  typedef logic signed [4:0] field_t;  // local field, -8..+8
  typedef logic signed [7:0] xfield_t; // beta-scaled field, -120..+120

  // Symmetric coupling matrix, rows/cols in order A, B, Cin, S, Cout
  localparam coef_t J [NUM_BITS][NUM_BITS] = '{
    '{  3'sd0, -3'sd1, -3'sd1,  3'sd1,  3'sd2 },
    '{ -3'sd1,  3'sd0, -3'sd1,  3'sd1,  3'sd2 },
    '{ -3'sd1, -3'sd1,  3'sd0,  3'sd1,  3'sd2 },
    '{  3'sd1,  3'sd1,  3'sd1,  3'sd0, -3'sd2 },
    '{  3'sd2,  3'sd2,  3'sd2, -3'sd2,  3'sd0 }
  };

  // One step of the Galois LFSR
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  // Per-bit seed; an all-zero seed would lock the LFSR, so it is forced off zero
  function automatic logic [15:0] seed_for(input logic [15:0] base, input int k);
    logic [15:0] s;
    s = base ^ 16'(SEED_STEP * (k + 1));
    if (s == 16'h0000) s = 16'h0001;
    return s;
  endfunction

  // Contribution of one neighbour: J_kj * m_j with m_j = +/-1
  function automatic field_t field_term(input coef_t c, input logic b);
    return b ? field_t'(c) : -field_t'(c);
  endfunction

  // round(256*sigmoid(x)) clipped to 8 bits; saturated outside -7..+7
  function automatic logic [THR_W-1:0] tanh_threshold(input xfield_t x);
    logic [THR_W-1:0] t;
    t = 8'd0;
    if (x <= -8'sd8) begin
      t = 8'd0;
    end else if (x >= 8'sd8) begin
      t = 8'd255;
    end else begin
      case (x)
        -8'sd7: t = 8'd0;
        -8'sd6: t = 8'd1;
        -8'sd5: t = 8'd2;
        -8'sd4: t = 8'd5;
        -8'sd3: t = 8'd12;
        -8'sd2: t = 8'd31;
        -8'sd1: t = 8'd69;
         8'sd0: t = 8'd128;
         8'sd1: t = 8'd187;
         8'sd2: t = 8'd225;
         8'sd3: t = 8'd244;
         8'sd4: t = 8'd251;
         8'sd5: t = 8'd254;
         8'sd6: t = 8'd255;
         8'sd7: t = 8'd255;
        default: t = 8'd0;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/pbit_cell.sv
// One stochastic bit: private LFSR, field-to-threshold compare, state register.
// Latency: state updates one clock after sel/clamp are presented.
// No backpressure; clamp has priority over the random draw.
module pbit_cell
  import inv_pbit_pkg::*;
#(
  parameter logic [15:0] SEED   = 16'h0001,
  parameter int          PROB_W = THR_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic [1:0] clamp,
  input  xfield_t    x,
  output logic       state
);

  logic [15:0]       lfsr;
  logic [PROB_W-1:0] r;
  logic [PROB_W-1:0] thr;
  logic              draw;

  // The LUT is 8-bit wide, so PROB_W is expected to stay at its default
  assign r    = lfsr[PROB_W-1:0];
  assign thr  = PROB_W'(tanh_threshold(x));
  assign draw = (r < thr);

  // LFSR free-runs every cycle; state takes clamp, else resamples when selected
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr  <= SEED;
      state <= 1'b0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (clamp[1]) begin
        state <= clamp[0];
      end else if (sel) begin
        state <= draw;
      end
    end
  end

endmodule

// File: rtl/inv_full_adder_pbit.sv
// Five coupled p-bits forming an invertible full adder (A+B+Cin = 2*Cout+S).
// Latency: clamps land 1 clock later; one free bit resampled per clock (Gibbs sweep).
// No handshake; clamp changes simply take effect on the next edge.
module inv_full_adder_pbit
  import inv_pbit_pkg::*;
#(
  parameter logic [15:0] SEED_BASE = 16'hACE1,
  parameter int          PROB_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] I_0,
  input  logic [1:0] a_clamp,
  input  logic [1:0] b_clamp,
  input  logic [1:0] cin_clamp,
  input  logic [1:0] s_clamp,
  input  logic [1:0] cout_clamp,
  output logic [4:0] p_bits
);

  logic [2:0] ptr;
  logic [1:0] clamp [NUM_BITS];
  xfield_t    x     [NUM_BITS];

  assign clamp[IDX_A]    = a_clamp;
  assign clamp[IDX_B]    = b_clamp;
  assign clamp[IDX_CIN]  = cin_clamp;
  assign clamp[IDX_S]    = s_clamp;
  assign clamp[IDX_COUT] = cout_clamp;

  // Round-robin update pointer 0..4
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= 3'd0;
    end else if (ptr == 3'(NUM_BITS - 1)) begin
      ptr <= 3'd0;
    end else begin
      ptr <= ptr + 3'd1;
    end
  end

  // Local fields from registered states, scaled by beta; fits 8-bit signed
  always_comb begin
    field_t acc;
    for (int k = 0; k < NUM_BITS; k++) begin
      acc = '0;
      for (int j = 0; j < NUM_BITS; j++) begin
        acc = acc + field_term(J[k][j], p_bits[j]);
      end
      x[k] = xfield_t'($signed({1'b0, I_0})) * xfield_t'(acc);
    end
  end

  for (genvar k = 0; k < NUM_BITS; k++) begin : g_cell
    pbit_cell #(
      .SEED   (seed_for(SEED_BASE, k)),
      .PROB_W (PROB_W)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .sel   (ptr == 3'(k)),
      .clamp (clamp[k]),
      .x     (x[k]),
      .state (p_bits[k])
    );
  end

endmodule

// File: tb/tb_inv_full_adder_pbit.sv
// Bench for inv_full_adder_pbit: cycle-accurate Gibbs model plus statistics.
// The model evaluates the sigmoid with real arithmetic and an integer J matrix.
// Directed clamp scenarios; every cycle after reset is compared to the model.
module tb_inv_full_adder_pbit;

  logic       clk;
  logic       reset;
  logic [3:0] I_0;
  logic [1:0] a_clamp, b_clamp, cin_clamp, s_clamp, cout_clamp;
  logic [4:0] p_bits;

  int n_tests = 0;
  int n_fail  = 0;
  int n_model_prints = 0;

  inv_full_adder_pbit dut (
    .clk        (clk),
    .reset      (reset),
    .I_0        (I_0),
    .a_clamp    (a_clamp),
    .b_clamp    (b_clamp),
    .cin_clamp  (cin_clamp),
    .s_clamp    (s_clamp),
    .cout_clamp (cout_clamp),
    .p_bits     (p_bits)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  int JM [5][5] = '{
    '{ 0, -1, -1,  1,  2},
    '{-1,  0, -1,  1,  2},
    '{-1, -1,  0,  1,  2},
    '{ 1,  1,  1,  0, -2},
    '{ 2,  2,  2, -2,  0}
  };

  function automatic int model_thr(input int xv);
    real v;
    int  t;
    if (xv <= -8) return 0;
    if (xv >= 8) return 255;
    v = 256.0 / (1.0 + $exp(-1.0 * xv));
    t = $rtoi(v + 0.5);
    if (t > 255) t = 255;
    return t;
  endfunction

  function automatic int model_seed(input int k);
    return 'hACE1 ^ (('h1F35 * (k + 1)) & 'hFFFF);
  endfunction

  function automatic int model_lfsr(input int s);
    return (s & 1) ? ((s >> 1) ^ 'hB400) : (s >> 1);
  endfunction

  logic [4:0] mp;
  int         mptr;
  int         mlfsr [5];
  bit         mvalid = 0;

  always @(posedge clk) begin
    int k, fld, xv, r;
    logic [4:0] nxt;
    logic [9:0] cl;
    cl = {cout_clamp, s_clamp, cin_clamp, b_clamp, a_clamp};
    if (!reset) begin
      mp = 5'b0;
      mptr = 0;
      for (int i = 0; i < 5; i++) mlfsr[i] = model_seed(i);
      mvalid = 1;
    end else begin
      k = mptr;
      fld = 0;
      for (int j = 0; j < 5; j++) fld += JM[k][j] * (mp[j] ? 1 : -1);
      xv = int'(I_0) * fld;
      r = mlfsr[k] & 'hFF;
      nxt = mp;
      nxt[k] = (r < model_thr(xv));
      for (int i = 0; i < 5; i++) if (cl[2*i+1]) nxt[i] = cl[2*i];
      mp = nxt;
      for (int i = 0; i < 5; i++) mlfsr[i] = model_lfsr(mlfsr[i]);
      mptr = (mptr + 1) % 5;
    end
  end

  // Every cycle after the first reset edge, DUT must match the model exactly
  always @(negedge clk) begin
    if (mvalid) begin
      n_tests++;
      if (p_bits !== mp) begin
        n_fail++;
        if (n_model_prints < 10) begin
          n_model_prints++;
          $display("FAIL model_cmp t=%0t: p_bits=%b required %b", $time, p_bits, mp);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic apply(input logic [3:0] beta, input logic [4:0] en, input logic [4:0] val);
    I_0        = beta;
    a_clamp    = {en[0], val[0]};
    b_clamp    = {en[1], val[1]};
    cin_clamp  = {en[2], val[2]};
    s_clamp    = {en[3], val[3]};
    cout_clamp = {en[4], val[4]};
  endtask

  int hi_cnt [5];

  task automatic run_stats(input int n);
    for (int i = 0; i < 5; i++) hi_cnt[i] = 0;
    repeat (50) @(negedge clk);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) if (p_bits[i]) hi_cnt[i]++;
    end
  endtask

  logic [4:0] seq_a [2000];
  int seq_diff;

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0;
    apply(4'd1, 5'b11111, 5'b10101);
    repeat (3) @(negedge clk);
    chk("reset_zero", int'(p_bits), 0, 0);

    // Pin the model against hand-computed values
    chk("thr_0",   model_thr(0),   128, 128);
    chk("thr_p1",  model_thr(1),   187, 187);
    chk("thr_m1",  model_thr(-1),  69,  69);
    chk("thr_p3",  model_thr(3),   244, 244);
    chk("thr_p7",  model_thr(7),   255, 255);
    chk("thr_m7",  model_thr(-7),  0,   0);
    chk("thr_p8",  model_thr(8),   255, 255);
    chk("thr_m8",  model_thr(-8),  0,   0);
    chk("seed_0",  model_seed(0),  'hB3D4, 'hB3D4);
    chk("seed_4",  model_seed(4),  'h30E8, 'h30E8);
    chk("lfsr_1",  model_lfsr(1),  'hB400, 'hB400);
    chk("lfsr_2",  model_lfsr(2),  1, 1);

    // All five clamped: deterministic 10101 from the first edge on
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("all_clamped", int'(p_bits), 5'b10101, 5'b10101);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("reset_over_clamp", int'(p_bits), 0, 0);
    reset = 1'b1;

    // Forward 1+1+0: S=0, Cout=1
    apply(4'd8, 5'b00111, 5'b00011);
    run_stats(10000);
    chk("fwd110_s_low",     hi_cnt[3], 0,    499);
    chk("fwd110_cout_high", hi_cnt[4], 9501, 10000);

    // Forward 1+0+0 at low beta: S favoured, Cout disfavoured
    apply(4'd1, 5'b00111, 5'b00001);
    run_stats(10000);
    chk("fwd100_s_high",   hi_cnt[3], 5001, 10000);
    chk("fwd100_cout_low", hi_cnt[4], 0,    4999);

    // Inverse: S=1, Cout=1 forces A=B=Cin=1
    apply(4'd8, 5'b11000, 5'b11000);
    run_stats(10000);
    chk("inv_a_high",   hi_cnt[0], 9001, 10000);
    chk("inv_b_high",   hi_cnt[1], 9001, 10000);
    chk("inv_cin_high", hi_cnt[2], 9001, 10000);

    // Subtract: A=0, Cin=0, S=1 implies B=1, Cout=0
    apply(4'd8, 5'b01101, 5'b01000);
    run_stats(10000);
    chk("sub_b_high",   hi_cnt[1], 9001, 10000);
    chk("sub_cout_low", hi_cnt[4], 0,    999);

    // Infinite temperature, nothing clamped: fair coins, repeatable from reset
    apply(4'd0, 5'b00000, 5'b00000);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) hi_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (c < 2000) seq_a[c] = p_bits;
      for (int i = 0; i < 5; i++) if (p_bits[i]) hi_cnt[i]++;
    end
    for (int i = 0; i < 5; i++) chk($sformatf("beta0_bit%0d_fair", i), hi_cnt[i], 4000, 6000);

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seq_diff = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (p_bits !== seq_a[c]) seq_diff++;
    end
    chk("beta0_repeatable", seq_diff, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
